// File: rtl/piso_tx_pkg.sv
// Shared definitions for the framed PISO transmitter: FSM states and
// the frame-length helper used by RTL and verification alike.
package piso_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned clks_per_bit,
                                              input int unsigned stop_bits,
                                              input int unsigned parity_en);
        return (1 + data_w + parity_en + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Generic load/shift register, LSB serialised first, zero fill at MSB.
// Load has priority over shift.
module piso_shreg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              q_bit
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end else if (shift) begin
            data_d = {1'b0, data_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_bit = data_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Framed serial transmitter: start bit, LSB-first data, optional even
// parity, stop bit(s), with back-to-back loading in the last stop cycle.
module piso_tx_ctrl
    import piso_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic               parity_q, parity_d;
    logic               baud_end;
    logic               last_stop;
    logic               accept;
    logic               shift;
    logic               sh_bit;

    assign baud_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_stop = (state_q == STOP) && baud_end
                       && (bit_idx_q == BIT_W'(STOP_BITS - 1));
    // Ready is gated by the reset input so it reads 0 throughout reset.
    assign tx_ready  = rst && ((state_q == IDLE) || last_stop);
    assign accept    = tx_valid && tx_ready;
    assign shift     = (state_q == DATA) && baud_end;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
            STOP: begin
                // bit_idx counts stop bits here
                if (baud_end) begin
                    if (last_stop) begin
                        state_d = IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end
            end
            default: ;
        endcase
        // Accept overrides both the IDLE hold and the STOP->IDLE exit.
        if (accept) begin
            state_d   = START;
            baud_d    = '0;
            bit_idx_d = '0;
            parity_d  = ^tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
        end
    end

    piso_shreg #(
        .DATA_W(DATA_W)
    ) u_shreg (
        .clk  (clk),
        .rst_n(rst),
        .load (accept),
        .shift(shift),
        .d    (tx_data),
        .q_bit(sh_bit)
    );

    always_comb begin
        serial_out = 1'b1;
        case (state_q)
            START:   serial_out = 1'b0;
            DATA:    serial_out = sh_bit;
            PARITY:  serial_out = parity_q;
            default: serial_out = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = last_stop;

endmodule
